alu_ctrl_seq: RTL and testbench
===============================

// Module: alu_ctrl_seq
// PURPOSE
//  Registered, parametrised successor to the single-cycle ALU control decoder.
//  - Decodes ALUOp/func into an ALU control code, one pipeline stage, with valid/ready flow control.
//  - Sequences multi-cycle MULT/DIV operations: start pulse, busy counter, done pulse.
//  - Interlocks HI/LO hazards (MFHI/MFLO, back-to-back MULT/DIV).
//  - Sits between the main control unit and the EX-stage ALU and multiply/divide unit.
// PARAMETERS
//  OP_W        3   width of ALUOp
//  CTRL_W      4   width of ALU control code (>=4)
//  MULT_CYCLES 4   MULT/MULTU latency in cycles (>=2)
//  DIV_CYCLES  16  DIV/DIVU latency in cycles (>=2)
// PORTS
//  clk       in   1       clock
//  reset     in   1       synchronous reset, active high
//  valid_in  in   1       ALUOp/func valid this cycle
//  ready_in  out  1       stage accepts input (comb); accept = valid_in & ready_in
//  ALUOp     in   OP_W    operation class from main control
//  func      in   6       R-type funct field
//  stall_in  in   1       downstream stall; holds output register
//  salida    out  CTRL_W  registered ALU control code
//  valid_out out  1       salida valid
//  illegal   out  1       registered: accepted op had no decode
//  md_start  out  1       one-cycle pulse: MULT/DIV launched
//  md_kind   out  2       {is_div, is_unsigned}, registered with md_start
//  md_busy   out  1       MULT/DIV in progress
//  md_done   out  1       one-cycle pulse in final busy cycle
// BEHAVIOUR
//  Reset: salida=4'b1111, valid_out=0, illegal=0, md_start=0, md_kind=0, md_busy=0, md_done=0,
//  FSM=IDLE, counter=0. Reset mid-operation aborts; no md_done is issued.
//  Decode (codes zero-extended to CTRL_W):
//  - ALUOp 000 -> 0010; 001 -> 0110; 100 -> 0010; 101 -> 0000; 110 -> 0001.
//  - ALUOp 010, by func:
//    - 32/33 -> 0010; 34/35 -> 0110; 36 -> 0000; 37 -> 0001; 38 -> 0011; 39 -> 1100;
//      42 -> 0111; 43 -> 1000.
//    - 24 MULT, 25 MULTU, 26 DIV, 27 DIVU -> 1110, launch MD.
//    - 16 MFHI, 18 MFLO -> 1101 (HI/LO read).
//  - Any other ALUOp/func -> 1111, illegal=1. No held/latched values.
//  Latency: 1 cycle. salida/valid_out/illegal update on the edge after accept.
//  - stall_in=1: all outputs hold and ready_in=0.
//  - Not stalled, no accept: valid_out=0 next cycle, salida holds.
//  FSM IDLE/BUSY:
//  - IDLE + accepted MD op -> BUSY.
//    - counter = (is_div ? DIV_CYCLES : MULT_CYCLES) - 1.
//    - md_start=1 and md_kind latched on the same edge.
//  - BUSY: md_busy=1; counter decrements each cycle (stall_in does not freeze it).
//  - BUSY & counter==0: md_done=1 (comb).
//    - Next state IDLE, unless an MD op is accepted that cycle: stay BUSY, reload, md_start=1.
//  Interlock: ready_in = !stall_in & !(md_busy & counter!=0 & hz).
//  - hz = incoming is MULT/DIV/MFHI/MFLO.
//  - Non-HI/LO ops flow freely while busy.
//  Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)); no wrap, since it is reloaded before 0-1.
// TESTING
//  1. Reset, then ALUOp=010 func=42 valid 1 cycle -> next cycle salida=0111, valid_out=1, illegal=0;
//     following cycle valid_out=0.
//  2. ALUOp=010 func=5 -> salida=1111, illegal=1; ALUOp=011 -> same.
//  3. MULT at t0 (MULT_CYCLES=4) -> md_start@t1, md_busy t1..t4, md_done@t4.
//     MFLO offered t2 -> ready_in=0 until t4, accepted t4.
//  4. DIV offered in MULT's done cycle -> accepted; md_start again next edge, busy 16 cycles,
//     no idle gap.
//  5. stall_in=1 for 3 cycles during ADD -> salida/valid_out frozen; BUSY counter still decrements.
//  6. reset asserted mid-DIV -> next edge md_busy=0, no md_done, salida=1111.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with valid/ready flow control, plus a
// MULT/DIV sequencer that interlocks HI/LO readers while the unit is busy.
module alu_ctrl_seq #(
  parameter int OP_W        = 3,
  parameter int CTRL_W      = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [OP_W-1:0]   ALUOp,
  input  logic [5:0]        func,
  input  logic              stall_in,
  output logic [CTRL_W-1:0] salida,
  output logic              valid_out,
  output logic              illegal,
  output logic              md_start,
  output logic [1:0]        md_kind,
  output logic              md_busy,
  output logic              md_done
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [3:0] code;
  logic       bad_op, md_op, hilo_op, div_op, uns_op;
  logic       hz, cnt_zero, accept, launch;
  logic [CNT_W-1:0] load_val;

  always_comb begin
    code    = 4'b1111;
    bad_op  = 1'b1;
    md_op   = 1'b0;
    hilo_op = 1'b0;
    div_op  = 1'b0;
    uns_op  = 1'b0;
    case (ALUOp)
      OP_W'(3'b000): begin code = 4'b0010; bad_op = 1'b0; end
      OP_W'(3'b001): begin code = 4'b0110; bad_op = 1'b0; end
      OP_W'(3'b100): begin code = 4'b0010; bad_op = 1'b0; end
      OP_W'(3'b101): begin code = 4'b0000; bad_op = 1'b0; end
      OP_W'(3'b110): begin code = 4'b0001; bad_op = 1'b0; end
      OP_W'(3'b010): begin
        case (func)
          6'd32, 6'd33: begin code = 4'b0010; bad_op = 1'b0; end
          6'd34, 6'd35: begin code = 4'b0110; bad_op = 1'b0; end
          6'd36:        begin code = 4'b0000; bad_op = 1'b0; end
          6'd37:        begin code = 4'b0001; bad_op = 1'b0; end
          6'd38:        begin code = 4'b0011; bad_op = 1'b0; end
          6'd39:        begin code = 4'b1100; bad_op = 1'b0; end
          6'd42:        begin code = 4'b0111; bad_op = 1'b0; end
          6'd43:        begin code = 4'b1000; bad_op = 1'b0; end
          // funct 24..27: bit 1 selects divide, bit 0 selects unsigned
          6'd24, 6'd25, 6'd26, 6'd27: begin
            code   = 4'b1110;
            bad_op = 1'b0;
            md_op  = 1'b1;
            div_op = func[1];
            uns_op = func[0];
          end
          6'd16, 6'd18: begin code = 4'b1101; bad_op = 1'b0; hilo_op = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // HI/LO users wait only while a previous MULT/DIV still has cycles left;
  // in the final busy cycle they may enter, so back-to-back ops leave no gap.
  assign hz       = md_op | hilo_op;
  assign cnt_zero = (cnt_reg == '0);
  assign md_busy  = (state_reg == BUSY);
  assign md_done  = md_busy & cnt_zero;
  assign ready_in = !stall_in && !(md_busy && !cnt_zero && hz);
  assign accept   = valid_in & ready_in;
  assign launch   = accept & md_op;
  assign load_val = div_op ? DIV_LOAD : MULT_LOAD;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          state_next = BUSY;
          cnt_next   = load_val;
        end
      end
      BUSY: begin
        if (!cnt_zero) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (launch) begin
          cnt_next = load_val;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      salida    <= CTRL_W'(4'b1111);
      valid_out <= 1'b0;
      illegal   <= 1'b0;
      md_start  <= 1'b0;
      md_kind   <= 2'b00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      md_start  <= launch;
      if (launch) md_kind <= {div_op, uns_op};
      // A stall freezes the decode pipeline register but not the MD sequencer.
      if (!stall_in) begin
        valid_out <= accept;
        if (accept) begin
          salida  <= CTRL_W'(code);
          illegal <= bad_op;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode results go through a scoreboard queue,
// MULT/DIV sequencing and interlock are checked at fixed cycle offsets.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset, valid_in, ready_in, stall_in;
  logic [2:0] alu_op;
  logic [5:0] func;
  logic [3:0] salida;
  logic       valid_out, illegal, md_start, md_busy, md_done;
  logic [1:0] md_kind;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] sb[$];
  logic will_accept = 1'b0;
  logic prev_vo = 1'b0;

  always #5 clk = ~clk;

  alu_ctrl_seq dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .ALUOp(alu_op), .func(func), .stall_in(stall_in), .salida(salida),
    .valid_out(valid_out), .illegal(illegal), .md_start(md_start),
    .md_kind(md_kind), .md_busy(md_busy), .md_done(md_done)
  );

  // Reference decode: {illegal, code}
  function automatic logic [4:0] ref_dec(input logic [2:0] op, input logic [5:0] fn);
    case (op)
      3'b000: return 5'h02;
      3'b001: return 5'h06;
      3'b100: return 5'h02;
      3'b101: return 5'h00;
      3'b110: return 5'h01;
      3'b010: begin
        case (fn)
          6'd32, 6'd33: return 5'h02;
          6'd34, 6'd35: return 5'h06;
          6'd36: return 5'h00;
          6'd37: return 5'h01;
          6'd38: return 5'h03;
          6'd39: return 5'h0C;
          6'd42: return 5'h07;
          6'd43: return 5'h08;
          6'd24, 6'd25, 6'd26, 6'd27: return 5'h0E;
          6'd16, 6'd18: return 5'h0D;
          default: return 5'h1F;
        endcase
      end
      default: return 5'h1F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present inputs for the coming edge and check ready_in against the bench's expectation.
  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn,
                       input logic exp_rdy, input string tag);
    valid_in = v;
    alu_op   = op;
    func     = fn;
    #1;
    chk({tag, "_ready"}, ready_in, exp_rdy);
    will_accept = v & exp_rdy;
    if (will_accept && !reset && !stall_in) sb.push_back(ref_dec(op, fn));
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 6'd0, !stall_in, "idle");
  endtask

  task automatic tick();
    logic exp_vo;
    logic pop;
    logic [4:0] e;
    exp_vo = reset ? 1'b0 : (stall_in ? prev_vo : will_accept);
    pop    = !reset && !stall_in && will_accept;
    @(posedge clk);
    #1;
    chk("valid_out", valid_out, exp_vo);
    if (pop) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL sb_underflow observed=0 expected=1");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("salida", salida, e[3:0]);
        chk("illegal", illegal, e[4]);
      end
    end
    prev_vo     = exp_vo;
    will_accept = 1'b0;
    valid_in    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; stall_in = 1'b0; alu_op = 3'b000; func = 6'd0;
    tick(); tick();
    chk("rst_salida", salida, 4'hF);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_md_start", md_start, 1'b0);
    chk("rst_md_kind", md_kind, 2'b00);
    chk("rst_md_busy", md_busy, 1'b0);
    chk("rst_md_done", md_done, 1'b0);
    reset = 1'b0;
    idle(); tick();

    // SLT then bubble: salida holds, valid_out drops
    drive(1'b1, 3'b010, 6'd42, 1'b1, "slt"); tick();
    idle(); tick();
    chk("slt_hold", salida, 4'h7);

    // Illegal decodes and a mix of legal ones back to back
    drive(1'b1, 3'b010, 6'd5,  1'b1, "bad_func"); tick();
    drive(1'b1, 3'b011, 6'd32, 1'b1, "bad_op");   tick();
    drive(1'b1, 3'b101, 6'd0,  1'b1, "and_i");    tick();
    drive(1'b1, 3'b110, 6'd0,  1'b1, "or_i");     tick();
    drive(1'b1, 3'b010, 6'd39, 1'b1, "nor");      tick();
    drive(1'b1, 3'b010, 6'd43, 1'b1, "sltu");     tick();
    drive(1'b1, 3'b010, 6'd16, 1'b1, "mfhi_idle"); tick();
    drive(1'b1, 3'b111, 6'd42, 1'b1, "bad_op7");  tick();
    idle(); tick();

    // MULT at t0; MFLO offered t2 blocked until t4
    drive(1'b1, 3'b010, 6'd24, 1'b1, "mult"); tick();           // t1
    chk("mult_start", md_start, 1'b1);
    chk("mult_kind", md_kind, 2'b00);
    chk("mult_busy_t1", md_busy, 1'b1);
    chk("mult_done_t1", md_done, 1'b0);
    idle(); tick();                                             // t2
    chk("mult_start_pulse", md_start, 1'b0);
    drive(1'b1, 3'b010, 6'd18, 1'b0, "mflo_t2"); tick();        // t3
    chk("mult_busy_t3", md_busy, 1'b1);
    drive(1'b1, 3'b010, 6'd18, 1'b0, "mflo_t3"); tick();        // t4
    drive(1'b1, 3'b010, 6'd18, 1'b1, "mflo_t4");
    chk("mult_done_t4", md_done, 1'b1);
    tick();                                                     // t5
    chk("mult_busy_t5", md_busy, 1'b0);
    chk("mult_done_t5", md_done, 1'b0);

    // MULT then DIV in MULT's done cycle; stall mid-DIV
    drive(1'b1, 3'b010, 6'd25, 1'b1, "multu"); tick();          // t1
    chk("multu_kind", md_kind, 2'b01);
    idle(); tick();                                             // t2
    idle(); tick();                                             // t3
    idle(); tick();                                             // t4
    drive(1'b1, 3'b010, 6'd26, 1'b1, "div_in_done");
    chk("multu_done", md_done, 1'b1);
    tick();                                                     // t5
    chk("div_start", md_start, 1'b1);
    chk("div_busy", md_busy, 1'b1);
    chk("div_kind", md_kind, 2'b10);
    drive(1'b1, 3'b010, 6'd32, 1'b1, "add_busy"); tick();       // t6
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin                           // t7..t9
      drive(1'b1, 3'b001, 6'd0, 1'b0, "stalled");
      tick();
      chk("stall_salida", salida, 4'h2);
    end
    stall_in = 1'b0;
    drive(1'b1, 3'b001, 6'd0, 1'b1, "sub_busy"); tick();        // t10
    for (int t = 10; t < 19; t++) begin
      if (t == 12) drive(1'b1, 3'b010, 6'd27, 1'b0, "divu_blocked");
      else idle();
      tick();
    end                                                         // t19
    chk("div_busy_t19", md_busy, 1'b1);
    drive(1'b1, 3'b010, 6'd16, 1'b0, "mfhi_t19");
    chk("div_done_t19", md_done, 1'b0);
    tick();                                                     // t20
    drive(1'b1, 3'b010, 6'd16, 1'b1, "mfhi_t20");
    chk("div_done_t20", md_done, 1'b1);
    tick();                                                     // t21
    chk("div_busy_t21", md_busy, 1'b0);

    // Reset aborts a DIVU in flight
    drive(1'b1, 3'b010, 6'd27, 1'b1, "divu"); tick();
    chk("divu_kind", md_kind, 2'b11);
    for (int i = 0; i < 3; i++) begin idle(); tick(); end
    reset = 1'b1;
    idle(); tick();
    chk("abort_busy", md_busy, 1'b0);
    chk("abort_done", md_done, 1'b0);
    chk("abort_salida", salida, 4'hF);
    chk("abort_start", md_start, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      idle(); tick();
      chk("abort_no_done", md_done, 1'b0);
    end

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
